// File: rtl/piso_if.sv
// piso_if: parallel-word handshake and serial output bundle for piso_serializer.
interface piso_if #(parameter int WIDTH = 8) ();
  logic             i_valid;
  logic [WIDTH-1:0] i_data;
  logic             o_ready;
  logic             o_out;
  logic             o_svalid;
  logic             o_last;
  logic             o_done;
  modport master (output i_valid, i_data, input o_ready, o_out, o_svalid, o_last, o_done);
  modport slave  (input i_valid, i_data, output o_ready, o_out, o_svalid, o_last, o_done);
endinterface

// File: rtl/piso_serializer.sv
// piso_serializer: valid/ready parallel-in, one-bit-per-clock serial-out transmitter.
// Optional even-parity trailer bit is enabled by defining PISO_PARITY_EN.
module piso_serializer #(
  parameter int   WIDTH      = 8,
  parameter int   LSB_FIRST  = 0,
  parameter logic IDLE_LEVEL = 1'b0
) (
  input logic   i_clk,
  input logic   i_rst,
  piso_if.slave bus
);
`ifdef PISO_PARITY_EN
  localparam int FLEN = WIDTH + 1;
`else
  localparam int FLEN = WIDTH;
`endif
  localparam int CW = $clog2(WIDTH + 2);
  typedef enum logic {IDLE, SHIFT} state_t;
  state_t           state_q;
  logic [WIDTH-1:0] sh_q;
  logic [CW-1:0]    cnt_q;
  logic             out_q, svalid_q, last_q, done_q;
  logic             accept, first_d, data_d, next_d, last_d;
  logic [WIDTH-1:0] load_d, shift_d;
  assign bus.o_ready  = (state_q == IDLE) || last_q;
  assign bus.o_out    = out_q;
  assign bus.o_svalid = svalid_q;
  assign bus.o_last   = last_q;
  assign bus.o_done   = done_q;
  // sh_q always holds the not-yet-sent bits with the next one at its output end
  always_comb begin
    accept  = bus.i_valid && bus.o_ready;
    first_d = (LSB_FIRST != 0) ? bus.i_data[0] : bus.i_data[WIDTH-1];
    load_d  = (LSB_FIRST != 0) ? bus.i_data >> 1 : bus.i_data << 1;
    shift_d = (LSB_FIRST != 0) ? sh_q >> 1 : sh_q << 1;
    data_d  = (LSB_FIRST != 0) ? sh_q[0] : sh_q[WIDTH-1];
    last_d  = cnt_q == CW'(FLEN - 2);
  end
`ifdef PISO_PARITY_EN
  logic par_q;
  always_ff @(posedge i_clk)
    if (i_rst) par_q <= 1'b0;
    else if (accept) par_q <= ^bus.i_data;
  assign next_d = (cnt_q == CW'(WIDTH - 1)) ? par_q : data_d;
`else
  assign next_d = data_d;
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q  <= IDLE;
      sh_q     <= '0;
      cnt_q    <= '0;
      out_q    <= IDLE_LEVEL;
      svalid_q <= 1'b0;
      last_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= (state_q == SHIFT) && last_q;
      if (accept) begin
        state_q  <= SHIFT;
        sh_q     <= load_d;
        cnt_q    <= '0;
        out_q    <= first_d;
        svalid_q <= 1'b1;
        last_q   <= 1'b0;
      end else if (state_q == SHIFT && last_q) begin
        state_q  <= IDLE;
        cnt_q    <= '0;
        out_q    <= IDLE_LEVEL;
        svalid_q <= 1'b0;
        last_q   <= 1'b0;
      end else if (state_q == SHIFT) begin
        sh_q   <= shift_d;
        cnt_q  <= cnt_q + CW'(1);
        out_q  <= next_d;
        last_q <= last_d;
      end
    end
  end
endmodule

// File: tb/tb_piso_serializer.sv
// tb_piso_serializer: scoreboard bench driving an MSB-first and an LSB-first instance in lockstep.
module tb_piso_serializer;
  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int FLEN = W + 1;
`else
  localparam int FLEN = W;
`endif
  typedef struct packed {logic b; logic l;} ebit_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  piso_if #(.WIDTH(W)) b0 ();
  piso_if #(.WIDTH(W)) b1 ();
  assign b1.i_valid = b0.i_valid;
  assign b1.i_data  = b0.i_data;
  piso_serializer #(.WIDTH(W), .LSB_FIRST(0), .IDLE_LEVEL(1'b0)) u0 (.i_clk(clk), .i_rst(rst), .bus(b0.slave));
  piso_serializer #(.WIDTH(W), .LSB_FIRST(1), .IDLE_LEVEL(1'b1)) u1 (.i_clk(clk), .i_rst(rst), .bus(b1.slave));
  ebit_t q0[$], q1[$];
  int total = 0, bad = 0, nd0 = 0, nd1 = 0, base;
  bit mon_en = 1'b0;
  logic de0 = 1'b0, de1 = 1'b0;
  logic [W-1:0] rx0 = '0, rx1 = '0;
  ebit_t e0, e1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [W-1:0] w);
    for (int n = 0; n < FLEN; n++) begin
      q0.push_back('{b: (n < W) ? w[W-1-n] : ^w, l: (n == FLEN - 1)});
      q1.push_back('{b: (n < W) ? w[n] : ^w, l: (n == FLEN - 1)});
    end
  endtask

  always @(negedge clk) if (mon_en) begin
    e0 = '{b: 1'b0, l: 1'b0};
    check("done0", b0.o_done, de0);
    if (b0.o_done) nd0++;
    de0 = 1'b0;
    if (b0.o_svalid) begin
      check("q0_has_bit", q0.size() > 0, 1);
      if (q0.size() > 0) begin
        e0 = q0.pop_front();
        check("out0", b0.o_out, e0.b);
        check("last0", b0.o_last, e0.l);
        de0 = e0.l;
        rx0 = {rx0[W-2:0], b0.o_out};
      end
    end else begin
      check("idle_out0", b0.o_out, 0);
      check("idle_last0", b0.o_last, 0);
    end
    check("ready0", b0.o_ready, !b0.o_svalid || e0.l);
  end

  always @(negedge clk) if (mon_en) begin
    e1 = '{b: 1'b0, l: 1'b0};
    check("done1", b1.o_done, de1);
    if (b1.o_done) nd1++;
    de1 = 1'b0;
    if (b1.o_svalid) begin
      check("q1_has_bit", q1.size() > 0, 1);
      if (q1.size() > 0) begin
        e1 = q1.pop_front();
        check("out1", b1.o_out, e1.b);
        check("last1", b1.o_last, e1.l);
        de1 = e1.l;
        rx1 = {b1.o_out, rx1[W-1:1]};
      end
    end else begin
      check("idle_out1", b1.o_out, 1);
      check("idle_last1", b1.o_last, 0);
    end
    check("ready1", b1.o_ready, !b1.o_svalid || e1.l);
  end

  task automatic send(input logic [W-1:0] w, input bit junk);
    bit ok = 1'b0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      b0.i_valid = 1'b1;
      if (b0.o_ready) begin
        b0.i_data = w;
        push(w);
        ok = 1'b1;
      end else b0.i_data = junk ? W'($urandom) : w;
    end
    check("accept", ok, 1);
    @(posedge clk);
  endtask

  task automatic drain();
    @(negedge clk);
    b0.i_valid = 1'b0;
    for (int i = 0; i < 60 && (q0.size() + q1.size()) != 0; i++) @(negedge clk);
    check("drain", q0.size() + q1.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic reset_state(input string tag);
    check({tag, "_ready0"}, b0.o_ready, 1);
    check({tag, "_out0"}, b0.o_out, 0);
    check({tag, "_svalid0"}, b0.o_svalid, 0);
    check({tag, "_last0"}, b0.o_last, 0);
    check({tag, "_done0"}, b0.o_done, 0);
    check({tag, "_out1"}, b1.o_out, 1);
    check({tag, "_svalid1"}, b1.o_svalid, 0);
  endtask

  initial begin
    b0.i_valid = 1'b0;
    b0.i_data  = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    reset_state("reset");
    mon_en = 1'b1;
    base = nd0;
    send(8'hA5, 1'b0);
    drain();
    check("frames_a5", nd0 - base, 1);
`ifndef PISO_PARITY_EN
    check("rx_a5", rx0, 8'hA5);
`endif
    base = nd0;
    send(8'h3C, 1'b0);
    send(8'hC3, 1'b0);
    drain();
    check("frames_b2b", nd0 - base, 2);
    check("frames_b2b_lsb", nd1 - base, 2);
    send(8'h5A, 1'b0);
    send(8'h96, 1'b1);
    drain();
`ifndef PISO_PARITY_EN
    check("rx_hold", rx0, 8'h96);
`endif
    send(8'h01, 1'b0);
    drain();
`ifndef PISO_PARITY_EN
    check("rx_lsb_01", rx1, 8'h01);
`endif
    send(8'h07, 1'b0);
    drain();
    send(8'hA5, 1'b0);
    repeat (3) @(negedge clk);
    check("third_bit", b0.o_out, 1);
    #1;
    mon_en = 1'b0;
    b0.i_valid = 1'b0;
    rst = 1'b1;
    q0.delete();
    q1.delete();
    de0 = 1'b0;
    de1 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    reset_state("midreset");
    @(negedge clk);
    check("midreset_nodone", b0.o_done, 0);
    check("midreset_nodone1", b1.o_done, 0);
    mon_en = 1'b1;
    send(8'h81, 1'b0);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
